// File: rtl/alu_result_pkg.sv
// Shared constants and the packed writeback entry for the ALU result stage.
package alu_result_pkg;

  localparam int DATA_W = 16;
  localparam int FLAG_W = 3;
  localparam int WNUM_W = 3;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] z;
    logic [WNUM_W-1:0] wnum;
    logic              write;
    logic              loads;
  } entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Two-entry valid/ready skid FIFO carrying an alu_result_pkg::entry_t.
// Ready/valid are pure functions of the registered occupancy.
module alu_result_fifo
  import alu_result_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  entry_t     in_entry,
  output logic       out_valid,
  input  logic       out_ready,
  output entry_t     out_entry,
  output logic [1:0] count
);

  generate
    if (DEPTH != 2) begin : g_depth_check
      $error("alu_result_fifo supports DEPTH = 2 only");
    end
  endgenerate

  entry_t     mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] count_r;
  logic [1:0] count_nxt_s;
  logic       push_s;
  logic       pop_s;

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign out_entry = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Next occupancy from the push/pop pair; push-and-pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_entry;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: skid FIFO toward register-file writeback plus the committed status register.
// Optional sticky-overflow flag is enabled by defining STICKY_OVF_EN.
module alu_result_stage
  import alu_result_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_out,
  input  logic [FLAG_W-1:0] in_z,
  input  logic [WNUM_W-1:0] in_wnum,
  input  logic              in_write,
  input  logic              in_loads,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [WNUM_W-1:0] out_wnum,
  output logic              out_write,
  output logic [FLAG_W-1:0] status,
  output logic [1:0]        count,
  output logic              sticky_v,
  input  logic              clr_sticky
);

  entry_t            in_entry_s;
  entry_t            head_s;
  logic              pop_s;
  logic [FLAG_W-1:0] status_r;

  assign in_entry_s = '{data: in_out, z: in_z, wnum: in_wnum, write: in_write, loads: in_loads};

  alu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_entry  (in_entry_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_entry (head_s),
    .count     (count)
  );

  assign pop_s     = out_valid & out_ready;
  assign out_data  = head_s.data;
  assign out_wnum  = head_s.wnum;
  assign out_write = head_s.write & out_valid;
  assign status    = status_r;

  // Architectural flags follow commit order: only a popped loads entry changes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_r <= '0;
    end else if (pop_s && head_s.loads) begin
      status_r <= head_s.z;
    end else begin
      status_r <= status_r;
    end
  end

`ifdef STICKY_OVF_EN
  logic sticky_r;
  logic sticky_set_s;

  assign sticky_set_s = pop_s & head_s.loads & head_s.z[FLAG_V];
  assign sticky_v     = sticky_r;

  // Sticky overflow; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_r <= 1'b0;
    end else if (sticky_set_s) begin
      sticky_r <= 1'b1;
    end else if (clr_sticky) begin
      sticky_r <= 1'b0;
    end else begin
      sticky_r <= sticky_r;
    end
  end
`else
  logic unused_clr_s;

  assign unused_clr_s = clr_sticky;
  assign sticky_v     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: queue-based reference model plus directed literal checks.
module tb_alu_result_stage;

`ifdef STICKY_OVF_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] data;
    logic [2:0]  z;
    logic [2:0]  wnum;
    logic        write;
    logic        loads;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_out = 16'h0000;
  logic [2:0]  in_z = 3'b000;
  logic [2:0]  in_wnum = 3'd0;
  logic        in_write = 1'b0;
  logic        in_loads = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  out_wnum;
  logic        out_write;
  logic [2:0]  status;
  logic [1:0]  count;
  logic        sticky_v;
  logic        clr_sticky = 1'b0;

  int checks = 0;
  int errors = 0;

  item_t      q[$];
  logic [2:0] m_status = 3'b000;
  logic       m_sticky = 1'b0;

  alu_result_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_out     (in_out),
    .in_z       (in_z),
    .in_wnum    (in_wnum),
    .in_write   (in_write),
    .in_loads   (in_loads),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_wnum   (out_wnum),
    .out_write  (out_write),
    .status     (status),
    .count      (count),
    .sticky_v   (sticky_v),
    .clr_sticky (clr_sticky)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: a FIFO of items, flags committed when an item leaves.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      q.delete();
      m_status = 3'b000;
      m_sticky = 1'b0;
    end else begin
      bit    do_push;
      bit    do_pop;
      bit    set_v;
      item_t head;
      item_t ni;
      do_push = in_valid && (q.size() < 2);
      do_pop  = (q.size() > 0) && out_ready;
      set_v   = 1'b0;
      ni.data = in_out; ni.z = in_z; ni.wnum = in_wnum; ni.write = in_write; ni.loads = in_loads;
      if (do_pop) begin
        head = q.pop_front();
        if (head.loads) begin
          m_status = head.z;
          set_v    = head.z[1];
        end
      end
      m_sticky = STICKY_EN && (set_v || (m_sticky && !clr_sticky));
      if (do_push) q.push_back(ni);
    end
  end

  // Compare DUT against the model away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    chk("count", count, q.size());
    chk("status", status, m_status);
    chk("sticky_v", sticky_v, m_sticky);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0].data);
      chk("out_wnum", out_wnum, q[0].wnum);
      chk("out_write", out_write, q[0].write);
    end else begin
      chk("out_write_idle", out_write, 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] z,
                       input logic [2:0] w, input logic wr, input logic ld);
    in_valid = v; in_out = d; in_z = z; in_wnum = w; in_write = wr; in_loads = ld;
  endtask

  initial begin
    #12;
    chk("rst_count", count, 2'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_status", status, 3'b000);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_write", out_write, 1'b0);
    chk("rst_sticky", sticky_v, 1'b0);
    step();
    reset = 1'b0;
    step();

    // Basic flow
    out_ready = 1'b1;
    drive(1'b1, 16'h0005, 3'b000, 3'd3, 1'b1, 1'b1);
    step();
    drive(1'b0, 16'hDEAD, 3'b111, 3'd7, 1'b1, 1'b1);
    chk("basic_valid", out_valid, 1'b1);
    chk("basic_data", out_data, 16'h0005);
    chk("basic_wnum", out_wnum, 3'd3);
    chk("basic_write", out_write, 1'b1);
    step();
    chk("basic_count", count, 2'd0);
    chk("basic_status", status, 3'b000);

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 16'h1111, 3'b011, 3'd1, 1'b1, 1'b0); step();
    drive(1'b1, 16'h2222, 3'b011, 3'd2, 1'b0, 1'b0); step();
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_count", count, 2'd2);
    drive(1'b1, 16'h3333, 3'b011, 3'd4, 1'b1, 1'b0); step();
    chk("bp_blocked", count, 2'd2);
    chk("bp_head", out_data, 16'h1111);
    out_ready = 1'b1;
    step();
    chk("bp_second", out_data, 16'h2222);
    chk("bp_count1", count, 2'd1);
    step();
    chk("bp_third", out_data, 16'h3333);
    drive(1'b0, 16'h0000, 3'b000, 3'd0, 1'b0, 1'b0);
    step();
    chk("bp_drained", count, 2'd0);

    // Status ordering
    out_ready = 1'b0;
    drive(1'b1, 16'h4444, 3'b100, 3'd5, 1'b1, 1'b1); step();
    drive(1'b1, 16'h5555, 3'b001, 3'd6, 1'b1, 1'b0); step();
    drive(1'b0, 16'h0000, 3'b000, 3'd0, 1'b0, 1'b0);
    chk("ord_stalled", status, 3'b000);
    out_ready = 1'b1;
    step();
    chk("ord_first", status, 3'b100);
    step();
    chk("ord_second", status, 3'b100);
    chk("ord_count", count, 2'd0);

    // Simultaneous push/pop
    out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 3'b000, 3'd1, 1'b1, 1'b0); step();
    out_ready = 1'b1;
    drive(1'b1, 16'hBBBB, 3'b000, 3'd2, 1'b1, 1'b0); step();
    drive(1'b0, 16'h0000, 3'b000, 3'd0, 1'b0, 1'b0);
    chk("pp_count", count, 2'd1);
    chk("pp_data", out_data, 16'hBBBB);
    step();

    // Sticky overflow
    out_ready = 1'b0;
    drive(1'b1, 16'h0101, 3'b010, 3'd1, 1'b1, 1'b1); step();
    drive(1'b1, 16'h0202, 3'b000, 3'd2, 1'b1, 1'b1); step();
    drive(1'b0, 16'h0000, 3'b000, 3'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("stk_set", sticky_v, STICKY_EN);
    chk("stk_status", status, 3'b010);
    step();
    chk("stk_hold", sticky_v, STICKY_EN);
    out_ready = 1'b0;
    drive(1'b1, 16'h0303, 3'b010, 3'd3, 1'b1, 1'b1); step();
    drive(1'b0, 16'h0000, 3'b000, 3'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    clr_sticky = 1'b1;
    step();
    chk("stk_set_wins", sticky_v, STICKY_EN);
    step();
    chk("stk_clear", sticky_v, 1'b0);
    clr_sticky = 1'b0;

    // Reset mid-operation with count 2 and status 010
    drive(1'b1, 16'h0404, 3'b010, 3'd4, 1'b1, 1'b1); step();
    drive(1'b0, 16'h0000, 3'b000, 3'd0, 1'b0, 1'b0);
    step();
    out_ready = 1'b0;
    drive(1'b1, 16'h0505, 3'b111, 3'd5, 1'b1, 1'b1); step();
    drive(1'b1, 16'h0606, 3'b111, 3'd6, 1'b1, 1'b1); step();
    drive(1'b0, 16'h0000, 3'b000, 3'd0, 1'b0, 1'b0);
    chk("mr_pre_count", count, 2'd2);
    chk("mr_pre_status", status, 3'b010);
    chk("mr_pre_sticky", sticky_v, STICKY_EN);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_count", count, 2'd0);
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_status", status, 3'b000);
    chk("mr_sticky", sticky_v, 1'b0);
    chk("mr_write", out_write, 1'b0);
    step();
    reset = 1'b0;
    step();

    // Mixed traffic, model-checked every cycle
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom), 3'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      out_ready  = 1'($urandom_range(0, 1));
      clr_sticky = ($urandom_range(0, 3) == 0);
      step();
    end
    drive(1'b0, 16'h0000, 3'b000, 3'd0, 1'b0, 1'b0);
    out_ready  = 1'b1;
    clr_sticky = 1'b0;
    step();
    step();
    step();
    chk("final_empty", count, 2'd0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
